// File: rtl/adc_ctrl_pkg.sv
// Shared encodings for the ADC capture controller.
package adc_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARMED   = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_DRAIN   = 2'd3
   } state_e;

   localparam logic [1:0] TRIG_IMMEDIATE = 2'd0;
   localparam logic [1:0] TRIG_RISE      = 2'd1;
   localparam logic [1:0] TRIG_FALL      = 2'd2;

endpackage

// File: rtl/adc_frame_buf.sv
// Frame buffer: simple dual-port RAM with a synchronous, enable-gated read port.
// The read register holds its word while re is low, so it doubles as the
// output prefetch stage of the drain stream.
module adc_frame_buf #(
   parameter  int unsigned DW    = 10,
   parameter  int unsigned DEPTH = 256,
   localparam int unsigned AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem [DEPTH];
   logic [DW-1:0] rdata_q;
   logic [DW-1:0] rdata_d;

   // Write port; the array itself carries no reset.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   // Read data advances only when a new word is requested.
   always_comb begin
      rdata_d = rdata_q;
      if (re) rdata_d = mem[raddr];
   end

   // Read register is reset so the drained data output starts at zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rdata_q <= '0;
      else        rdata_q <= rdata_d;
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/adc_capture_ctrl.sv
// ADC capture sequencer: decimate, trigger, record one frame, drain it on valid/ready.
module adc_capture_ctrl
   import adc_ctrl_pkg::*;
#(
   parameter  int unsigned DW      = 10,
   parameter  int unsigned DEPTH   = 256,
   parameter  int unsigned DECIM_W = 8,
   localparam int unsigned AW      = $clog2(DEPTH),
   localparam int unsigned LW      = AW + 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [DW-1:0]      adc_data,
   input  logic [DECIM_W-1:0] decim,
   input  logic [1:0]         trig_mode,
   input  logic [DW-1:0]      trig_level,
   input  logic [LW-1:0]      frame_len,
   input  logic               arm,
   input  logic               abort,
   output logic [DW-1:0]      rd_data,
   output logic               rd_valid,
   input  logic               rd_ready,
   output logic               rd_last,
   output logic               busy,
   output logic               triggered,
   output logic               done,
   output logic [1:0]         state
);

   state_e             state_q, state_d;
   logic [DECIM_W-1:0] decim_q, decim_d;
   logic [DECIM_W-1:0] dcnt_q, dcnt_d;
   logic [1:0]         mode_q, mode_d;
   logic [DW-1:0]      level_q, level_d;
   logic [DW-1:0]      prev_q, prev_d;
   logic               prev_valid_q, prev_valid_d;
   logic [LW-1:0]      len_q, len_d;
   logic [LW-1:0]      wr_ptr_q, wr_ptr_d;
   logic [LW-1:0]      rd_cnt_q, rd_cnt_d;
   logic               triggered_q, triggered_d;
   logic               rd_valid_q, rd_valid_d;
   logic               rd_last_q, rd_last_d;
   logic               done_q, done_d;
   logic               busy_q, busy_d;

   logic               stb_c;
   logic               trig_c;
   logic               we_c;
   logic               re_c;
   logic [LW-1:0]      len_clamp_c;

   // Sample strobe and trigger condition for the current strobe.
   always_comb begin
      stb_c       = (dcnt_q == decim_q);
      len_clamp_c = ((frame_len == '0) || (frame_len > LW'(DEPTH))) ? LW'(DEPTH) : frame_len;
      case (mode_q)
         TRIG_RISE: trig_c = prev_valid_q && (prev_q < level_q) && (adc_data >= level_q);
         TRIG_FALL: trig_c = prev_valid_q && (prev_q > level_q) && (adc_data <= level_q);
         default:   trig_c = 1'b1;
      endcase
   end

   // Next-state and datapath control; abort overrides everything.
   always_comb begin
      state_d      = state_q;
      decim_d      = decim_q;
      dcnt_d       = dcnt_q;
      mode_d       = mode_q;
      level_d      = level_q;
      prev_d       = prev_q;
      prev_valid_d = prev_valid_q;
      len_d        = len_q;
      wr_ptr_d     = wr_ptr_q;
      rd_cnt_d     = rd_cnt_q;
      triggered_d  = triggered_q;
      rd_valid_d   = rd_valid_q;
      rd_last_d    = rd_last_q;
      done_d       = 1'b0;
      we_c         = 1'b0;
      re_c         = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (arm) begin
               decim_d      = decim;
               mode_d       = trig_mode;
               level_d      = trig_level;
               len_d        = len_clamp_c;
               dcnt_d       = '0;
               wr_ptr_d     = '0;
               rd_cnt_d     = '0;
               prev_valid_d = 1'b0;
               state_d      = ST_ARMED;
            end
         end
         ST_ARMED: begin
            dcnt_d = stb_c ? '0 : dcnt_q + DECIM_W'(1);
            if (stb_c) begin
               prev_d       = adc_data;
               prev_valid_d = 1'b1;
               if (trig_c) begin
                  we_c        = 1'b1;
                  wr_ptr_d    = LW'(1);
                  triggered_d = 1'b1;
                  state_d     = (len_q == LW'(1)) ? ST_DRAIN : ST_CAPTURE;
               end
            end
         end
         ST_CAPTURE: begin
            dcnt_d = stb_c ? '0 : dcnt_q + DECIM_W'(1);
            if (stb_c) begin
               we_c     = 1'b1;
               wr_ptr_d = wr_ptr_q + LW'(1);
               if (wr_ptr_q == len_q - LW'(1)) state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            dcnt_d = '0;
            if (!rd_valid_q) begin
               // First cycle in DRAIN: prefetch word 0.
               re_c       = 1'b1;
               rd_cnt_d   = LW'(1);
               rd_valid_d = 1'b1;
               rd_last_d  = (len_q == LW'(1));
            end else if (rd_ready) begin
               if (rd_last_q) begin
                  rd_valid_d = 1'b0;
                  rd_last_d  = 1'b0;
                  rd_cnt_d   = '0;
                  done_d     = 1'b1;
                  state_d    = ST_IDLE;
               end else begin
                  re_c      = 1'b1;
                  rd_cnt_d  = rd_cnt_q + LW'(1);
                  rd_last_d = (rd_cnt_q + LW'(1) == len_q);
               end
            end
         end
      endcase

      if (abort) begin
         state_d      = ST_IDLE;
         dcnt_d       = '0;
         wr_ptr_d     = '0;
         rd_cnt_d     = '0;
         prev_valid_d = 1'b0;
         rd_valid_d   = 1'b0;
         rd_last_d    = 1'b0;
         done_d       = 1'b0;
         we_c         = 1'b0;
         re_c         = 1'b0;
      end

      if (state_d == ST_IDLE) triggered_d = 1'b0;
      busy_d = (state_d != ST_IDLE);
   end

   // State and control registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         decim_q      <= '0;
         dcnt_q       <= '0;
         mode_q       <= '0;
         level_q      <= '0;
         prev_q       <= '0;
         prev_valid_q <= 1'b0;
         len_q        <= '0;
         wr_ptr_q     <= '0;
         rd_cnt_q     <= '0;
         triggered_q  <= 1'b0;
         rd_valid_q   <= 1'b0;
         rd_last_q    <= 1'b0;
         done_q       <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         decim_q      <= decim_d;
         dcnt_q       <= dcnt_d;
         mode_q       <= mode_d;
         level_q      <= level_d;
         prev_q       <= prev_d;
         prev_valid_q <= prev_valid_d;
         len_q        <= len_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_cnt_q     <= rd_cnt_d;
         triggered_q  <= triggered_d;
         rd_valid_q   <= rd_valid_d;
         rd_last_q    <= rd_last_d;
         done_q       <= done_d;
         busy_q       <= busy_d;
      end
   end

   adc_frame_buf #(
      .DW    (DW),
      .DEPTH (DEPTH)
   ) u_buf (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (we_c),
      .waddr (wr_ptr_q[AW-1:0]),
      .wdata (adc_data),
      .re    (re_c),
      .raddr (rd_cnt_q[AW-1:0]),
      .rdata (rd_data)
   );

   assign rd_valid  = rd_valid_q;
   assign rd_last   = rd_last_q;
   assign busy      = busy_q;
   assign triggered = triggered_q;
   assign done      = done_q;
   assign state     = state_q;

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Directed + randomized bench for adc_capture_ctrl with a frame-level reference model.
module tb_adc_capture_ctrl;

   localparam int DW      = 10;
   localparam int DEPTH   = 256;
   localparam int DECIM_W = 8;
   localparam int LW      = 9;
   localparam int NSAMP   = 4096;

   logic               clk;
   logic               rst_n;
   logic [DW-1:0]      adc_data;
   logic [DECIM_W-1:0] decim;
   logic [1:0]         trig_mode;
   logic [DW-1:0]      trig_level;
   logic [LW-1:0]      frame_len;
   logic               arm;
   logic               abort;
   logic [DW-1:0]      rd_data;
   logic               rd_valid;
   logic               rd_ready;
   logic               rd_last;
   logic               busy;
   logic               triggered;
   logic               done;
   logic [1:0]         state;

   int errors = 0;
   int checks = 0;
   int samp [NSAMP];

   adc_capture_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .adc_data   (adc_data),
      .decim      (decim),
      .trig_mode  (trig_mode),
      .trig_level (trig_level),
      .frame_len  (frame_len),
      .arm        (arm),
      .abort      (abort),
      .rd_data    (rd_data),
      .rd_valid   (rd_valid),
      .rd_ready   (rd_ready),
      .rd_last    (rd_last),
      .busy       (busy),
      .triggered  (triggered),
      .done       (done),
      .state      (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   task automatic fill_ramp(input int base, input int step);
      for (int i = 0; i < NSAMP; i++) begin
         int v;
         v = base + step * i;
         if (v < 0) v = 0;
         if (v > 530 && step > 0 && base >= 500) v = 530;
         if (v > 1023) v = 1023;
         samp[i] = v;
      end
   endtask

   task automatic fill_random();
      for (int i = 0; i < NSAMP; i++) samp[i] = int'($urandom_range(0, 1023));
   endtask

   // Arms at cycle 0 with samp[i] presented in cycle i; checks the drained frame
   // against the sample list predicted from the strobe/trigger rules.
   task automatic run_frame(input int mode, input int lvl, input int dec, input int flen,
                            input int rdy_pct, input bit arm_in_drain);
      int   len, trig_i, last_s, n, last_hs, prev;
      bit   pv, hit, fin, stalled, armed_again;
      int   exp_q[$];
      logic [DW-1:0] p_data;
      logic p_last;

      len    = (flen == 0 || flen > DEPTH) ? DEPTH : flen;
      trig_i = -1;
      last_s = -1;
      pv     = 1'b0;
      prev   = 0;
      for (int i = 1 + dec; i < NSAMP; i += dec + 1) begin
         if (trig_i < 0) begin
            case (mode)
               1:       hit = pv && prev < lvl && samp[i] >= lvl;
               2:       hit = pv && prev > lvl && samp[i] <= lvl;
               default: hit = 1'b1;
            endcase
            pv   = 1'b1;
            prev = samp[i];
            if (hit) trig_i = i;
         end
         if (trig_i >= 0 && exp_q.size() < len) begin
            exp_q.push_back(samp[i]);
            last_s = i;
         end
      end

      @(negedge clk);
      chk("idle_before_arm", 32'({busy, state}), 32'(0));
      arm        = 1'b1;
      decim      = DECIM_W'(dec);
      trig_mode  = 2'(mode);
      trig_level = DW'(lvl);
      frame_len  = LW'(flen);
      adc_data   = DW'(samp[0]);
      rd_ready   = 1'b0;
      n = 0; last_hs = -1; fin = 1'b0; stalled = 1'b0; armed_again = 1'b0;
      p_data = '0; p_last = 1'b0;

      for (int i = 1; i < NSAMP && !fin; i++) begin
         @(negedge clk);
         arm        = 1'b0;
         decim      = DECIM_W'($urandom);
         trig_mode  = 2'($urandom);
         trig_level = DW'($urandom);
         frame_len  = LW'($urandom);
         adc_data   = DW'(samp[i]);
         rd_ready   = (int'($urandom_range(0, 99)) < rdy_pct);
         if (arm_in_drain && !armed_again && state == 2'd3) begin
            arm = 1'b1;
            armed_again = 1'b1;
         end
         if (i == 1) chk("armed_entry", 32'({busy, state}), 32'(3'b101));
         if (i == trig_i) chk("trig_before", 32'(triggered), 32'(0));
         if (i == trig_i + 1) chk("trig_after", 32'(triggered), 32'(1));
         if (i == last_s + 1) chk("drain_entry", 32'({state, rd_valid}), 32'(3'b110));
         if (i == last_s + 2) chk("first_valid", 32'(rd_valid), 32'(1));
         if (stalled) chk("stall_hold", 32'({rd_valid, rd_last, rd_data}), 32'({1'b1, p_last, p_data}));
         if (last_hs >= 0 && i == last_hs + 1) begin
            chk("done_pulse", 32'({done, busy, triggered, rd_valid, state}), 32'(6'b100000));
            fin = 1'b1;
         end else if (done === 1'b1) begin
            chk("early_done", 32'(done), 32'(0));
            fin = 1'b1;
         end
         if (!fin && rd_valid === 1'b1 && rd_ready) begin
            if (n < len) begin
               chk($sformatf("word%0d", n), 32'(rd_data), 32'(exp_q[n]));
               chk($sformatf("last%0d", n), 32'(rd_last), 32'(n == len - 1));
               n++;
               if (n == len) last_hs = i;
            end else begin
               chk("extra_word", 32'(rd_valid), 32'(0));
            end
         end
         stalled = (rd_valid === 1'b1) && !rd_ready;
         p_data  = rd_data;
         p_last  = rd_last;
      end
      arm = 1'b0;
      chk("frame_words", 32'(n), 32'(len));
      chk("frame_done", 32'(fin), 32'(1));
      @(negedge clk);
      chk("done_single", 32'({done, rd_valid, state}), 32'(0));
   endtask

   initial begin
      bit seen;
      rst_n = 1'b1; arm = 1'b0; abort = 1'b0; rd_ready = 1'b0;
      adc_data = '0; decim = '0; trig_mode = '0; trig_level = '0; frame_len = '0;
      #3 rst_n = 1'b0;
      #4;
      chk("reset_outputs", 32'({rd_data, rd_valid, rd_last, busy, triggered, done, state}), 32'(0));
      @(negedge clk);
      rst_n = 1'b1;

      // Immediate trigger on a ramp: arm sees 10, frame is 11..14.
      fill_ramp(10, 1);
      run_frame(0, 0, 0, 4, 100, 1'b0);

      // Rising and falling threshold crossings at 512.
      fill_ramp(500, 1);
      run_frame(1, 512, 0, 8, 100, 1'b0);
      fill_ramp(530, -1);
      run_frame(2, 512, 0, 8, 100, 1'b0);

      // Decimation by 4, also with mode 3 acting as immediate.
      fill_ramp(20, 1);
      run_frame(0, 0, 3, 4, 100, 1'b0);
      run_frame(3, 900, 2, 5, 100, 1'b0);

      // Backpressure on the drain stream.
      fill_ramp(40, 3);
      run_frame(0, 0, 1, 16, 30, 1'b0);

      // Abort after two of eight writes.
      fill_ramp(200, 1);
      @(negedge clk);
      arm = 1'b1; trig_mode = 2'd0; decim = '0; frame_len = LW'(8); rd_ready = 1'b1;
      adc_data = DW'(samp[0]);
      for (int i = 1; i <= 3; i++) begin
         @(negedge clk);
         arm = 1'b0;
         adc_data = DW'(samp[i]);
      end
      chk("pre_abort", 32'({triggered, state}), 32'(3'b110));
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("post_abort", 32'({state, busy, triggered, rd_valid, rd_last}), 32'(0));
      seen = 1'b0;
      repeat (12) begin
         @(negedge clk);
         seen = seen | rd_valid | done;
      end
      chk("abort_quiet", 32'(seen), 32'(0));

      // arm and abort together: abort wins.
      arm = 1'b1; abort = 1'b1;
      @(negedge clk);
      arm = 1'b0; abort = 1'b0;
      chk("arm_abort_same", 32'({busy, state}), 32'(0));
      run_frame(0, 0, 0, 8, 100, 1'b0);

      // Frame length corners, and arm while draining.
      fill_ramp(0, 1);
      run_frame(0, 0, 0, 0, 100, 1'b0);
      run_frame(0, 0, 0, 300, 70, 1'b0);
      fill_ramp(77, 2);
      run_frame(0, 0, 1, 1, 50, 1'b1);
      run_frame(0, 0, 0, 6, 60, 1'b1);

      // Randomized configurations on random data.
      for (int k = 0; k < 8; k++) begin
         fill_random();
         run_frame(int'($urandom_range(0, 3)), int'($urandom_range(200, 800)),
                   int'($urandom_range(0, 3)), int'($urandom_range(1, 16)),
                   int'($urandom_range(30, 100)), bit'($urandom_range(0, 1)));
      end

      // Asynchronous reset while a word is waiting in DRAIN.
      fill_ramp(100, 1);
      @(negedge clk);
      arm = 1'b1; trig_mode = 2'd0; decim = '0; frame_len = LW'(4); rd_ready = 1'b0;
      adc_data = DW'(samp[0]);
      for (int i = 1; i < 20 && rd_valid !== 1'b1; i++) begin
         @(negedge clk);
         arm = 1'b0;
         adc_data = DW'(samp[i]);
      end
      chk("rst_reach_drain", 32'({rd_valid, state}), 32'(3'b111));
      #2 rst_n = 1'b0;
      #1;
      chk("rst_async", 32'({rd_data, rd_valid, rd_last, busy, triggered, done, state}), 32'(0));
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_release_idle", 32'({busy, state}), 32'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
